// File: rtl/otter_divider.sv
// -----------------------------------------------------------------------------
// otter_divider
//
// Iterative RV32M divide unit for the execute stage. Computes DIV, DIVU, REM
// and REMU with a radix-2 restoring algorithm, producing one quotient bit
// per clock. A start/busy/valid handshake connects it to the pipeline: the
// hazard unit stalls while o_busy is high, and the writeback mux takes
// o_result when o_valid pulses.
//
// Ports:
//   i_clk     clock, all state updates on the rising edge
//   i_rst     synchronous reset, active-high
//   i_start   request, accepted only in IDLE (and not in the o_valid cycle)
//   i_op      funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_src_a   dividend (rs1), sampled on acceptance
//   i_src_b   divisor  (rs2), sampled on acceptance
//   i_kill    abort the in-flight operation (pipeline flush)
//   o_busy    high from the cycle after acceptance until o_valid rises
//   o_valid   one-cycle result strobe
//   o_result  quotient or remainder, held until the next o_valid
// -----------------------------------------------------------------------------
module otter_divider #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_src_a,
    input  logic [XLEN-1:0] i_src_b,
    input  logic            i_kill,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [XLEN-1:0]  ONE      = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]  ONES     = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's complement negation.
    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
        return ~v + ONE;
    endfunction

    // Magnitude of v; only signed operations treat the MSB as a sign.
    // The most negative value maps onto itself, which as an unsigned
    // magnitude is exactly right.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                  input logic is_signed);
        return (is_signed && v[XLEN-1]) ? negate(v) : v;
    endfunction

    // Control state (reset)
    state_t          state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic            valid_q,  valid_d;
    logic [XLEN-1:0] result_q, result_d;

    // Datapath state (no reset needed; always loaded on acceptance)
    logic            op_rem_q,  op_rem_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] div_q,     div_d;
    logic [XLEN-1:0] rem_q,     rem_d;
    logic [XLEN-1:0] quo_q,     quo_d;

    // One restoring step. The shifted remainder needs XLEN+1 bits because an
    // unsigned divisor can exceed 2^(XLEN-1). When it is >= the divisor the
    // true difference is below the divisor, so XLEN-bit modular subtraction
    // of the low bits yields it exactly.
    logic [XLEN:0]   rem_sh;
    logic            rem_ge;
    logic [XLEN-1:0] rem_step;
    logic            acc_signed;

    assign rem_sh     = {rem_q, quo_q[XLEN-1]};
    assign rem_ge     = (rem_sh >= {1'b0, div_q});
    assign rem_step   = rem_ge ? (rem_sh[XLEN-1:0] - div_q) : rem_sh[XLEN-1:0];
    assign acc_signed = ~i_op[0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        valid_d   = 1'b0;
        result_d  = result_q;
        op_rem_d  = op_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        div_d     = div_q;
        rem_d     = rem_q;
        quo_d     = quo_q;

        unique case (state_q)
            IDLE: begin
                // The o_valid cycle still belongs to the finished operation.
                if (i_start && !i_kill && !valid_q) begin
                    op_rem_d  = i_op[1];
                    cnt_d     = '0;
                    rem_d     = '0;
                    neg_quo_d = 1'b0;
                    neg_rem_d = 1'b0;
                    div_d     = i_src_b;
                    if (i_src_b == '0) begin
                        // Divide by zero: preload the architected results.
                        quo_d   = ONES;
                        rem_d   = i_src_a;
                        state_d = DONE;
                    end else if (acc_signed && (i_src_a == MIN_NEG) && (i_src_b == ONES)) begin
                        // Signed overflow: -2^(XLEN-1) / -1.
                        quo_d   = MIN_NEG;
                        state_d = DONE;
                    end else begin
                        neg_quo_d = acc_signed & (i_src_a[XLEN-1] ^ i_src_b[XLEN-1]);
                        neg_rem_d = acc_signed & i_src_a[XLEN-1];
                        quo_d     = magnitude(i_src_a, acc_signed);
                        div_d     = magnitude(i_src_b, acc_signed);
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                if (i_kill) begin
                    state_d = IDLE;
                end else begin
                    rem_d = rem_step;
                    quo_d = {quo_q[XLEN-2:0], rem_ge};
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!i_kill) begin
                    if (op_rem_q) begin
                        result_d = neg_rem_q ? negate(rem_q) : rem_q;
                    end else begin
                        result_d = neg_quo_q ? negate(quo_q) : quo_q;
                    end
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    always_ff @(posedge i_clk) begin
        op_rem_q  <= op_rem_d;
        neg_quo_q <= neg_quo_d;
        neg_rem_q <= neg_rem_d;
        div_q     <= div_d;
        rem_q     <= rem_d;
        quo_q     <= quo_d;
    end

    assign o_busy   = (state_q != IDLE);
    assign o_valid  = valid_q;
    assign o_result = result_q;

endmodule

// File: tb/tb_otter_divider.sv
module tb_otter_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        kill;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    otter_divider #(.XLEN(32)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_op     (op),
        .i_src_a  (src_a),
        .i_src_b  (src_b),
        .i_kill   (kill),
        .o_busy   (busy),
        .o_valid  (valid),
        .o_result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic        prev_valid = 1'b0;
    logic [31:0] last_exp = 32'h0;

    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: RISC-V M-extension semantics from plain integer arithmetic.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb_, ua, ub;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua  = longint'({32'h0, a});
        ub  = longint'({32'h0, b});
        if (b == 32'h0) return o[1] ? a : 32'hFFFF_FFFF;
        case (o)
            2'b00:   return (a == MIN_NEG && b == 32'hFFFF_FFFF) ? MIN_NEG : 32'(sa / sb_);
            2'b01:   return 32'(ua / ub);
            2'b10:   return (a == MIN_NEG && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb_);
            default: return 32'(ua % ub);
        endcase
    endfunction

    // Monitor: every o_valid must match the oldest outstanding request.
    always @(negedge clk) begin
        if (valid) begin
            check("valid_not_consecutive", {31'h0, prev_valid}, 32'h0);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid actual=%h expected=no_valid", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result, e.res);
                check("latency", 32'(cyc - e.acc), 32'(e.lat));
                last_exp = e.res;
            end
        end
        prev_valid <= valid;
    end

    // Waits for idle, presents one request, leaves time just after the
    // accepting edge E0 with operands scrambled.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit expect_result);
        exp_t e;
        int   guard;
        guard = 0;
        while ((busy || valid) && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) check("issue_wait_timeout", 32'(guard), 32'h0);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
        op    = 2'($urandom);
        if (expect_result) begin
            e.res = model(o, a, b);
            e.acc = cyc;
            e.lat = ((b == 32'h0) || (!o[0] && a == MIN_NEG && b == 32'hFFFF_FFFF)) ? 1 : 33;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || busy) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain_outstanding", 32'(sb.size()), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        rst = 1'b1; start = 1'b0; op = 2'b00; src_a = 32'h0; src_b = 32'h0; kill = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_valid", {31'h0, valid}, 32'h0);
        check("reset_result", result, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: basic DIV with busy timing, then REM
        issue(2'b00, 32'd100, 32'd7, 1'b1);
        check("busy_after_E0", {31'h0, busy}, 32'h1);
        repeat (32) @(posedge clk);
        #1;
        check("busy_after_E32", {31'h0, busy}, 32'h1);
        check("valid_low_after_E32", {31'h0, valid}, 32'h0);
        @(posedge clk); #1;
        check("busy_after_E33", {31'h0, busy}, 32'h0);
        check("valid_after_E33", {31'h0, valid}, 32'h1);
        issue(2'b10, 32'd100, 32'd7, 1'b1);

        // 2: signed operands
        issue(2'b00, 32'hFFFF_FF9C, 32'd7, 1'b1);
        issue(2'b10, 32'hFFFF_FF9C, 32'd7, 1'b1);
        issue(2'b10, 32'd100, 32'hFFFF_FFF9, 1'b1);

        // 3: unsigned with large operands
        issue(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b1);
        issue(2'b11, 32'hFFFF_FFFF, 32'd2, 1'b1);
        issue(2'b01, 32'd5, 32'h8000_0000, 1'b1);

        // 4: corner cases
        issue(2'b00, 32'h1234_5678, 32'h0, 1'b1);
        issue(2'b10, 32'h1234_5678, 32'h0, 1'b1);
        issue(2'b00, MIN_NEG, 32'hFFFF_FFFF, 1'b1);
        issue(2'b10, MIN_NEG, 32'hFFFF_FFFF, 1'b1);
        issue(2'b01, 32'h0000_0009, 32'h0, 1'b1);
        issue(2'b11, 32'hDEAD_BEEF, 32'h0, 1'b1);
        drain();

        // start during the o_valid cycle is ignored
        issue(2'b00, 32'd42, 32'h0, 1'b1);
        @(posedge clk); #1;
        check("valid_special_E1", {31'h0, valid}, 32'h1);
        start = 1'b1; op = 2'b01; src_a = 32'd9; src_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_in_valid_ignored", {31'h0, busy}, 32'h0);

        // kill together with start in IDLE does not accept
        start = 1'b1; kill = 1'b1; op = 2'b01; src_a = 32'd9; src_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        check("kill_blocks_start", {31'h0, busy}, 32'h0);

        // 5: start while busy is ignored
        issue(2'b01, 32'd1000, 32'd10, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; op = 2'b01; src_a = 32'd9; src_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        issue(2'b01, 32'd9, 32'd3, 1'b1);
        drain();

        // 6a: kill mid-operation
        issue(2'b00, 32'd100, 32'd7, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_busy", {31'h0, busy}, 32'h0);
        check("kill_result_held", result, last_exp);
        repeat (40) @(posedge clk);
        #1;
        check("kill_result_still_held", result, last_exp);

        // 6b: reset mid-operation
        issue(2'b00, 32'd100, 32'd7, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_busy", {31'h0, busy}, 32'h0);
        check("rst_mid_valid", {31'h0, valid}, 32'h0);
        check("rst_mid_result", result, 32'h0);
        repeat (40) @(posedge clk);
        #1;
        issue(2'b00, 32'd100, 32'd7, 1'b1);
        drain();

        // random operations
        for (int i = 0; i < 60; i++) begin
            ro = 2'($urandom);
            ra = ($urandom_range(0, 7) == 0) ? MIN_NEG : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 20));
                3:       rb = -32'($urandom_range(1, 20));
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            if (($urandom_range(0, 3) == 0) && (rb != 32'h0)) ra = ra >> $urandom_range(0, 31);
            issue(ro, ra, rb, 1'b1);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/otter_divider.md
Name: otter_divider

Overview:
Iterative RV32M divide unit in the execute stage, beside otter_alu. It takes the same rs1/rs2 operands and produces DIV/DIVU/REM/REMU results for the writeback mux. It uses a radix-2 restoring algorithm, one quotient bit per clock, and a start/busy/valid handshake. The hazard logic stalls the pipeline while o_busy is high.

Parameters:
XLEN, 32, operand/result width; iteration counter width is $clog2(XLEN)

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst  input  1  synchronous reset, active-high
i_start  input  1  request; accepted only in IDLE
i_op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with i_start
i_src_a  input  XLEN  dividend (rs1); sampled with i_start
i_src_b  input  XLEN  divisor (rs2); sampled with i_start
i_kill  input  1  abort in-flight operation (pipeline flush)
o_busy  output  1  high from the cycle after acceptance until the cycle o_valid rises
o_valid  output  1  one-cycle pulse; o_result is valid in that cycle
o_result  output  XLEN  quotient or remainder; holds its value until the next o_valid

Behaviour:
- Reset (i_rst=1 at an edge): state IDLE, o_busy=0, o_valid=0, o_result=0, counter=0. Reset overrides start and kill. Reset mid-operation discards the operation with no valid pulse.
- States: IDLE, CALC, DONE.
- IDLE, i_start=1: latch op; compute sign flags and absolute values (signed ops only); clear the partial remainder; counter=0.
  - divisor==0: go to DONE.
  - Signed op with a=0x80000000 and b=0xFFFFFFFF: go to DONE.
  - Otherwise: go to CALC.
  - o_busy=1 from the next cycle.
- CALC: each edge shifts {rem,quo} left by 1. If rem_shifted >= |b|, subtract and set the quotient LSB. Counter increments. The edge performing iteration XLEN-1 goes to DONE.
- DONE: one edge applies the sign fix-up, registers o_result, pulses o_valid=1, clears o_busy, and returns to IDLE.
- Latency (accept edge = E0):
  - Normal ops: iterations on E1..E32, o_valid high after E33; o_busy high after E0..E32.
  - Special cases: o_valid high after E1.
- Sign rules:
  - Quotient is negated when sign(a) != sign(b).
  - Remainder takes the sign of the dividend.
  - Unsigned ops never negate.
- Corner values (RISC-V spec):
  - Divide by zero: quotient = all ones; remainder = dividend (unsigned and signed).
  - Signed overflow: quotient = 0x80000000; remainder = 0.
- Start handling:
  - i_start while not IDLE is ignored; operands and op are not re-sampled.
  - i_start in the same cycle o_valid is high is ignored (state is DONE→IDLE); the earliest next accept is the following cycle.
- Kill:
  - i_kill=1 in CALC or DONE: go to IDLE next edge, o_busy=0, no o_valid, o_result unchanged.
  - i_kill in IDLE has no effect; i_kill together with i_start in IDLE does not accept the start.
- Operand changes on i_src_a/i_src_b after acceptance do not affect the result.
- o_valid is never high for two consecutive cycles.

Test Plan:
1. Reset, then DIV a=100 b=7 → o_busy high after E0..E32; o_valid one cycle after E33; o_result=0x0000000E. Repeat as REM → 0x00000002.
2. DIV a=0xFFFFFF9C (-100) b=7 → 0xFFFFFFF2 (-14). REM same operands → 0xFFFFFFFE (-2). REM a=100 b=0xFFFFFFF9 → 0x00000002.
3. DIVU a=0xFFFFFFFF b=2 → 0x7FFFFFFF. REMU same operands → 0x00000001. DIVU a=0x00000005 b=0x80000000 → 0x00000000.
4. DIV a=0x12345678 b=0 → 0xFFFFFFFF, valid after E1. REM same → 0x12345678. DIV a=0x80000000 b=0xFFFFFFFF → 0x80000000. REM same → 0x00000000.
5. Start DIVU 1000/10, then pulse i_start with 9/3 at E5 → ignored; result 0x00000064 after E33. Immediately restart with 9/3 → 0x00000003.
6. Start DIV 100/7. i_kill at E10 → o_busy=0 after E11, no o_valid, o_result retains its previous value. Repeat with i_rst at E10 → all outputs 0, next start works normally.
